data_memory: RTL
================

Name: data_memory

Overview:
- Data memory stage directly downstream of the ALU in the single-cycle RISC-V datapath.
- ALUResult drives the byte address; rs2 drives store data.
- Performs RV32I loads and stores: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Reads are combinational and feed the writeback mux in the same cycle; writes commit on the clock edge.
- Detects misaligned and illegal accesses, suppresses them, and records the first fault in sticky registers.

Parameters:
- DEPTH, 64, number of 32-bit words; must be a power of two.
- ADDR_BITS, 6, log2(DEPTH); word index = Addr[ADDR_BITS+1:2].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MemWrite  input  1  store request this cycle.
- MemRead  input  1  load request this cycle.
- funct3  input  3  access width/sign (RV32I encoding).
- Addr  input  32  byte address (from ALUResult).
- WriteData  input  32  store data; the low bytes are used for SB/SH.
- ReadData  output  32  aligned, extended load result.
- misaligned  output  1  combinational: the current access is misaligned or illegal.
- faultSticky  output  1  registered: a fault has occurred since reset.
- faultAddr  output  32  registered: Addr of the first fault.

Behaviour:
- Reset values:
  - On a rising edge with reset=1, all DEPTH words clear to 0, faultSticky=0 and faultAddr=0.
  - ReadData is combinational, so it reads 0 in the cycle after reset.
  - Reset has priority over a simultaneous store. Reset asserted mid-stream discards that cycle's store.
- Addressing:
  - Upper address bits above ADDR_BITS+1 are ignored, so addresses wrap modulo DEPTH*4.
  - Byte lane = Addr[1:0].
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000, 001 and 010 only.
- misaligned=1 (combinational) when (MemRead|MemWrite) and any of the following holds:
  - halfword access with Addr[0]=1;
  - word access with Addr[1:0]!=00;
  - funct3 is illegal for the operation.
- Stores (MemWrite=1, misaligned=0, reset=0) update only the addressed lanes on the rising edge:
  - SB writes WriteData[7:0] to lane Addr[1:0].
  - SH writes WriteData[15:0] to lanes {Addr[1],0} and {Addr[1],1}.
  - SW writes all 4 lanes.
  - Little-endian: lane 0 = bits 7:0.
- Faulting stores are fully suppressed; the memory is unchanged.
- Loads, combinational with 0 cycles of latency:
  - The addressed word is read, the selected byte or halfword is shifted to bit 0, then sign- or zero-extended per funct3.
  - When MemRead=0, or misaligned=1, ReadData=0.
- MemRead and MemWrite both asserted:
  - The load returns the pre-edge contents (read-before-write); the store commits at the edge.
  - misaligned evaluates against the shared funct3 and Addr, and a fault suppresses both.
- Fault capture:
  - On a clock edge with misaligned=1 and faultSticky=0: faultSticky<=1 and faultAddr<=Addr.
  - Later faults do not overwrite faultAddr; only reset clears it.
- No X propagation: every output is defined for all input combinations.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - Default DEPTH.
- Sub-module load_extend (combinational):
  - inputs: 32-bit word, Addr[1:0], funct3;
  - output: the 32-bit extended result.
  - Reused later by any load/store unit.
- Lane write-enable generation stays inline in data_memory.

Test Plan:
- Word round-trip: reset; SW Addr=0x8, WriteData=0xDEADBEEF. Then LW 0x8 returns 0xDEADBEEF, and LW 0xC returns 0x00000000.
- Byte/half stores and extension: SW 0x0=0x00000000; SB 0x1 data=0x000000F0; SH 0x2 data=0x00008001.
  - LW 0x0 returns 0x8001F000.
  - LB 0x1 returns 0xFFFFFFF0; LBU 0x1 returns 0x000000F0.
  - LH 0x2 returns 0xFFFF8001; LHU 0x2 returns 0x00008001.
- Misaligned store: SW Addr=0x6 data=0x12345678.
  - misaligned=1 that cycle; memory word 1 is unchanged.
  - Next cycle faultSticky=1, faultAddr=0x6.
  - A second fault at 0x3 (LH) leaves faultAddr=0x6.
- Illegal funct3: MemRead, funct3=011, Addr=0x0 gives misaligned=1 and ReadData=0. Store with funct3=100 leaves memory unchanged.
- Wrap and read-before-write:
  - SW Addr=0x100 (DEPTH=64) writes word 0.
  - Same-cycle LW+SW at 0x4 (old value 0x11111111, new 0x22222222): the read shows 0x11111111 before the edge and 0x22222222 after it.
- Reset priority: SW 0x10=0xCAFEF00D with reset=1 in the same cycle. Afterwards LW 0x10 returns 0, and faultSticky=0 and faultAddr=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I data memory and load/store helpers:
// funct3 width/sign encodings and legality checks.
package mem_pkg;

  localparam int DEFAULT_DEPTH = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the datapath (master) and the data memory (slave).
interface data_memory_if;
  logic        MemWrite;
  logic        MemRead;
  logic [2:0]  funct3;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        misaligned;
  logic        faultSticky;
  logic [31:0] faultAddr;

  modport master (
    output MemWrite, MemRead, funct3, Addr, WriteData,
    input  ReadData, misaligned, faultSticky, faultAddr
  );

  modport slave (
    input  MemWrite, MemRead, funct3, Addr, WriteData,
    output ReadData, misaligned, faultSticky, faultAddr
  );
endinterface

// File: rtl/data_memory_load_extend.sv
// Selects the addressed byte/halfword of a word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {lane_i, 3'b000};

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = shifted;
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// RV32I data memory: combinational loads, byte-lane stores on the clock edge,
// misalignment/illegal-access suppression with sticky first-fault capture.
module data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          reset,
  data_memory_if.slave bus
);

  logic [31:0]          mem_q [DEPTH];
  logic                 fault_sticky_q, fault_sticky_d;
  logic [31:0]          fault_addr_q, fault_addr_d;

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           lane;
  logic                 is_half, is_word, access, illegal, mis;
  logic                 store_en;
  logic [3:0]           lane_we;
  logic [31:0]          wdata_rep;
  logic [31:0]          load_data;

  assign word_idx = bus.Addr[ADDR_BITS+1:2];
  assign lane     = bus.Addr[1:0];
  assign is_half  = (bus.funct3[1:0] == 2'b01);
  assign is_word  = (bus.funct3[1:0] == 2'b10);
  assign access   = bus.MemRead | bus.MemWrite;
  assign illegal  = (bus.MemRead  & ~load_f3_ok(bus.funct3)) |
                    (bus.MemWrite & ~store_f3_ok(bus.funct3));
  assign mis      = access & (illegal | (is_half & lane[0]) |
                              (is_word & (lane != 2'b00)));
  assign store_en = bus.MemWrite & ~mis;

  always_comb begin
    lane_we   = 4'b0000;
    wdata_rep = bus.WriteData;
    case (bus.funct3)
      F3_B: begin
        lane_we   = 4'b0001 << lane;
        wdata_rep = {4{bus.WriteData[7:0]}};
      end
      F3_H: begin
        lane_we   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.WriteData[15:0]}};
      end
      F3_W:    lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (store_en) begin
      for (int l = 0; l < 4; l++)
        if (lane_we[l]) mem_q[word_idx][8*l +: 8] <= wdata_rep[8*l +: 8];
    end
  end

  load_extend u_load_extend (
    .word_i   (mem_q[word_idx]),
    .lane_i   (lane),
    .funct3_i (bus.funct3),
    .data_o   (load_data)
  );

  // Only the first fault since reset is recorded.
  always_comb begin
    fault_sticky_d = fault_sticky_q;
    fault_addr_d   = fault_addr_q;
    if (mis && !fault_sticky_q) begin
      fault_sticky_d = 1'b1;
      fault_addr_d   = bus.Addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_sticky_q <= 1'b0;
      fault_addr_q   <= '0;
    end else begin
      fault_sticky_q <= fault_sticky_d;
      fault_addr_q   <= fault_addr_d;
    end
  end

  assign bus.ReadData    = (bus.MemRead && !mis) ? load_data : 32'h0;
  assign bus.misaligned  = mis;
  assign bus.faultSticky = fault_sticky_q;
  assign bus.faultAddr   = fault_addr_q;

endmodule
